// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: load wait, extraction/extension, register file write pulse
// Optional misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_write,
    input  logic            in_is_load,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_result,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wd,
    output logic            wb_busy
`ifdef WB_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [4:0]      p_rd;
    logic            p_we;
    logic [2:0]      p_funct3;
    logic [1:0]      p_addr_lo;
    logic            xfer;
    logic            misaligned;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;

    assign in_ready = (state == IDLE);
    assign wb_busy  = (state == WAIT);
    assign xfer     = in_valid && in_ready;

`ifdef WB_MISALIGN_TRAP_EN
    // Reserved funct3 encodings count as word loads here too.
    always_comb begin
        misaligned = 1'b0;
        if (in_is_load) begin
            case (in_funct3)
                3'b000, 3'b100: misaligned = 1'b0;
                3'b001, 3'b101: misaligned = in_addr_lo[0];
                default:        misaligned = (in_addr_lo != 2'b00);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= xfer && misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (xfer && in_is_load && !misaligned) state_n = WAIT;
            WAIT: if (mem_rvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        ld_byte   = mem_rdata[{p_addr_lo, 3'b000} +: 8];
        ld_half   = mem_rdata[{p_addr_lo[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (p_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    // wb_we defaults low every cycle so each retiring write is a single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_wd     <= '0;
            p_rd      <= 5'd0;
            p_we      <= 1'b0;
            p_funct3  <= 3'b000;
            p_addr_lo <= 2'b00;
        end else begin
            wb_we <= 1'b0;
            if (state == WAIT) begin
                if (mem_rvalid) begin
                    wb_we <= p_we && (p_rd != 5'd0);
                    wb_rd <= p_rd;
                    wb_wd <= load_data;
                end
            end else if (xfer) begin
                if (in_is_load) begin
                    if (!misaligned) begin
                        p_rd      <= in_rd;
                        p_we      <= in_reg_write;
                        p_funct3  <= in_funct3;
                        p_addr_lo <= in_addr_lo;
                    end
                end else begin
                    wb_we <= in_reg_write && (in_rd != 5'd0);
                    wb_rd <= in_rd;
                    wb_wd <= in_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (both WB_MISALIGN_TRAP_EN builds)
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic        in_is_load = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [1:0]  in_addr_lo = 2'b00;
    logic [31:0] in_result = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_busy;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg_write (in_reg_write),
        .in_is_load   (in_is_load),
        .in_rd        (in_rd),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_result    (in_result),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_wd        (wb_wd),
        .wb_busy      (wb_busy)
`ifdef WB_MISALIGN_TRAP_EN
        ,
        .misalign_trap(misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write, in its exact cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_write: no wb_we for rd %0d expected in cycle %0d", q[0].rd, q[0].cyc);
            void'(q.pop_front());
        end
        if (wb_we) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: wb_we=1 rd %0d wd %h, none expected (cycle %0d)", wb_rd, wb_wd, cyc);
            end else begin
                e = q.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_wd", wb_wd, e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        e.cyc = cyc + 1;
        e.rd  = rd;
        e.wd  = wd;
        q.push_back(e);
    endtask

    task automatic send_nl(input logic [4:0] rd, input logic we, input logic [31:0] res);
        check("ready_before_nl", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is_load = 1'b0; in_reg_write = we; in_rd = rd; in_result = res;
        if (we && rd != 5'd0) expect_write(rd, res);
        step();
        in_valid = 1'b0;
    endtask

    task automatic accept_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a);
        in_valid = 1'b1; in_is_load = 1'b1; in_reg_write = 1'b1; in_rd = rd;
        in_funct3 = f3; in_addr_lo = a; in_result = 32'hBAD0_BAD0;
        step();
        in_valid = 1'b0; in_is_load = 1'b0;
    endtask

    // Load accepted, response arrives 'delay' cycles after acceptance.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                           input logic [31:0] data, input int delay, input logic [31:0] exp_wd);
        accept_load(rd, f3, a);
        check("busy_in_wait", {31'd0, wb_busy}, 32'd1);
        check("ready_in_wait", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i < delay; i++) step();
        mem_rvalid = 1'b1; mem_rdata = data;
        expect_write(rd, exp_wd);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h5555_AAAA;
        check("ready_after_load", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        step();
        step();
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_wd", wb_wd, 32'd0);
        check("rst_wb_busy", {31'd0, wb_busy}, 32'd0);
`ifdef WB_MISALIGN_TRAP_EN
        check("rst_trap", {31'd0, misalign_trap}, 32'd0);
`endif
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Non-loads, back-to-back, including x0 and reg_write=0.
        send_nl(5'd5, 1'b1, 32'h1234_5678);
        send_nl(5'd0, 1'b1, 32'hFFFF_FFFF);
        send_nl(5'd31, 1'b1, 32'h0000_0001);
        send_nl(5'd6, 1'b0, 32'h7777_7777);
        send_nl(5'd8, 1'b1, 32'hA5A5_5A5A);
        step();

        // Load extraction and extension on 0x80FF_0011.
        do_load(5'd1, 3'b000, 2'd3, 32'h80FF_0011, 3, 32'hFFFF_FF80);
        do_load(5'd2, 3'b100, 2'd3, 32'h80FF_0011, 3, 32'h0000_0080);
        do_load(5'd3, 3'b001, 2'd2, 32'h80FF_0011, 1, 32'hFFFF_80FF);
        do_load(5'd4, 3'b101, 2'd0, 32'h80FF_0011, 2, 32'h0000_0011);
        do_load(5'd9, 3'b000, 2'd2, 32'h80FF_0011, 1, 32'hFFFF_FFFF);
        do_load(5'd10, 3'b100, 2'd0, 32'h80FF_0011, 1, 32'h0000_0011);
        do_load(5'd11, 3'b101, 2'd2, 32'h80FF_0011, 1, 32'h0000_80FF);
        do_load(5'd12, 3'b010, 2'd0, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);
        do_load(5'd13, 3'b011, 2'd0, 32'h80FF_0011, 1, 32'h80FF_0011);
        do_load(5'd14, 3'b001, 2'd0, 32'h0000_7FFE, 1, 32'h0000_7FFE);

        // Load to x0 never writes.
        accept_load(5'd0, 3'b010, 2'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        step();
        mem_rvalid = 1'b0;

        // Stall: non-load to rd 7 held while the load waits.
        accept_load(5'd20, 3'b000, 2'd1);
        in_valid = 1'b1; in_is_load = 1'b0; in_reg_write = 1'b1; in_rd = 5'd7; in_result = 32'hCAFE_0007;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000;
        expect_write(5'd20, 32'hFFFF_FF80);
        step();
        mem_rvalid = 1'b0;
        check("stall_release_ready", {31'd0, in_ready}, 32'd1);
        expect_write(5'd7, 32'hCAFE_0007);
        step();
        in_valid = 1'b0;
        step();

        // Reset during WAIT drops the load, with a response in the reset cycle.
        accept_load(5'd15, 3'b010, 2'd0);
        step();
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        step();
        rst = 1'b0; mem_rvalid = 1'b0;
        check("rst_wait_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wait_busy", {31'd0, wb_busy}, 32'd0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("rst_wait_no_we", {31'd0, wb_we}, 32'd0);

        // Reset beats a simultaneous transfer.
        rst = 1'b1; in_valid = 1'b1; in_is_load = 1'b0; in_reg_write = 1'b1; in_rd = 5'd9; in_result = 32'h9999_9999;
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Spurious response in IDLE.
        mem_rvalid = 1'b1; mem_rdata = 32'hFEED_FACE;
        step();
        mem_rvalid = 1'b0;
        check("spurious_we", {31'd0, wb_we}, 32'd0);
        check("spurious_busy", {31'd0, wb_busy}, 32'd0);
        check("spurious_ready", {31'd0, in_ready}, 32'd1);

`ifdef WB_MISALIGN_TRAP_EN
        accept_load(5'd16, 3'b010, 2'd2);
        check("trap_pulse", {31'd0, misalign_trap}, 32'd1);
        check("trap_we", {31'd0, wb_we}, 32'd0);
        check("trap_busy", {31'd0, wb_busy}, 32'd0);
        step();
        check("trap_single", {31'd0, misalign_trap}, 32'd0);
        accept_load(5'd17, 3'b101, 2'd1);
        check("trap_lhu", {31'd0, misalign_trap}, 32'd1);
        step();
        do_load(5'd18, 3'b001, 2'd2, 32'h80FF_0011, 1, 32'hFFFF_80FF);
        check("aligned_no_trap", {31'd0, misalign_trap}, 32'd0);
`else
        do_load(5'd16, 3'b010, 2'd2, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
        do_load(5'd17, 3'b001, 2'd3, 32'h80FF_0011, 1, 32'hFFFF_80FF);
`endif

        for (int i = 0; i < 4; i++) step();
        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I core: takes retiring instructions from the memory stage, waits for data-memory load responses, and sign/zero-extends load data. It drives the register file write port (write enable, destination index, write data) through one registered pulse per retired write. It stalls the memory stage with a ready/valid handshake while a load is outstanding.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage accepts; a transfer occurs when in_valid && in_ready.
- in_reg_write  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load; data comes from mem_rdata.
- in_rd  in  5  destination register index.
- in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  low bits of the load byte address.
- in_result  in  XLEN  ALU/PC+4 result for non-loads.
- mem_rvalid  in  1  data memory returns load data this cycle.
- mem_rdata  in  XLEN  word-aligned load data, little-endian.
- wb_we  out  1  register file write enable.
- wb_rd  out  5  register file write index.
- wb_wd  out  XLEN  register file write data.
- wb_busy  out  1  load outstanding (state WAIT).
- misalign_trap  out  1  present only with WB_MISALIGN_TRAP_EN; one-cycle trap pulse.

## Operation
- States: IDLE, WAIT. in_ready = (state == IDLE).
- IDLE, transfer, in_is_load = 0: latch rd and in_result. Next cycle: wb_we = in_reg_write && (in_rd != 0), wb_rd = in_rd, wb_wd = in_result. Stay in IDLE.
- IDLE, transfer, in_is_load = 1: latch rd, reg_write, funct3 and addr_lo, then go to WAIT. wb_we = 0 next cycle.
- WAIT: in_ready = 0 and mem_rvalid is sampled each cycle. On mem_rvalid, extract and extend the data, register it to wb_*, and return to IDLE.
- Extraction:
  - LB/LBU: byte mem_rdata[8*addr_lo +: 8].
  - LH/LHU: halfword mem_rdata[16*addr_lo[1] +: 16].
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - funct3 011, 110 and 111 are treated as LW.
- Writes to x0 never assert wb_we. wb_rd and wb_wd may carry values while wb_we = 0, and consumers must ignore them.
- mem_rvalid while in IDLE is ignored and does not change state or outputs.
- wb_we is a single-cycle pulse per retiring write; it never repeats for the same instruction.

## Timing
- Reset values: state = IDLE, wb_we = 0, wb_rd = 0, wb_wd = 0, wb_busy = 0, misalign_trap = 0. in_ready is 1 in the cycle after rst deasserts.
- Non-load latency: accepted in cycle N, wb_we in cycle N+1. Throughput is one per cycle.
- Load latency: accepted in cycle N, mem_rvalid in cycle M ≥ N+1, wb_we in cycle M+1. in_ready returns to 1 in cycle M+1, and a transfer in cycle M+1 writes in M+2. Back-to-back writes are legal.
- rst during WAIT: return to IDLE and drop the pending load, so it is never written. A mem_rvalid in the reset cycle is ignored. wb_we = 0 in the following cycle.
- rst has priority over a simultaneous transfer; the transfer is lost.
- Downstream, the register file captures on the same clk edge following the wb_we cycle. This stage adds no write-data bypass.

## Configuration
- WB_MISALIGN_TRAP_EN defined:
  - A load is misaligned when it is LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0.
  - A misaligned load stays in IDLE and never enters WAIT.
  - misalign_trap pulses in cycle N+1 and wb_we stays 0.
  - The memory stage suppresses the request under the same condition, so no mem_rvalid follows.
- WB_MISALIGN_TRAP_EN undefined:
  - The misalign_trap port does not exist.
  - LH/LHU ignore addr_lo[0] and LW ignores addr_lo entirely.
  - Every load enters WAIT.

## Test plan
- Non-load: rst, then transfer rd = 5, reg_write = 1, result = 0x1234_5678 -> wb_we = 1, wb_rd = 5, wb_wd = 0x1234_5678 in exactly one cycle, the next one.
- Load extension: LB with addr_lo = 3, mem_rdata = 0x80FF_0011 three cycles later -> wb_wd = 0xFFFF_FF80. LBU with the same data -> 0x0000_0080. LH with addr_lo = 2 -> 0xFFFF_80FF. LHU with addr_lo = 0 -> 0x0000_0011.
- Stall: during WAIT, in_valid is held high with a non-load to rd = 7 -> in_ready = 0 until the mem_rvalid cycle. Then the load writes in cycle M+1 and rd = 7 writes in cycle M+2.
- x0 and reset: non-load to rd = 0 -> wb_we stays 0. Load accepted, rst in WAIT, then mem_rvalid -> no write, state IDLE, in_ready = 1.
- Spurious response: mem_rvalid = 1 in IDLE with no transfer -> wb_we = 0 and wb_busy = 0.
- Macro: with WB_MISALIGN_TRAP_EN, LW with addr_lo = 2 -> misalign_trap = 1 for one cycle, wb_we = 0, wb_busy = 0. Without the macro, the same load with mem_rdata = 0xDEAD_BEEF -> wb_wd = 0xDEAD_BEEF.
